// File: rtl/dpu_pipe_if.sv
// Handshake and result bus of the pipelined datapath unit.
// The master drives operands and consumes results; the slave is the pipeline.
interface dpu_pipe_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         acc_sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;

    modport master (
        output in_valid, a, b, op, acc_sel, out_ready,
        input  in_ready, out_valid, result, carry, zero
    );

    modport slave (
        input  in_valid, a, b, op, acc_sel, out_ready,
        output in_ready, out_valid, result, carry, zero
    );
endinterface

// File: rtl/dpu_pipe.sv
// Two-stage pipelined datapath unit: an input register (S1) feeds an ALU
// whose result is captured in an output register (S2) together with flags
// and an accumulator. A debug mux and a scanned hex 7-segment driver expose
// the latest result.
module dpu_pipe #(
    parameter int W        = 8,
    parameter int DIGITS   = W / 4,
    parameter int SCAN_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    dpu_pipe_if.slave         bus,
    input  logic [1:0]        dsel,
    output logic [W-1:0]      dout,
    output logic [1:7]        seg,
    output logic [DIGITS-1:0] an
);
    typedef enum logic [2:0] {
        OP_A   = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_AND = 3'b011,
        OP_SUB = 3'b100,
        OP_ADD = 3'b101,
        OP_B   = 3'b110,
        OP_CLR = 3'b111
    } op_t;

    localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [W-1:0]    s1_a;
    logic [W-1:0]    s1_b;
    op_t             s1_op;
    logic            s1_acc_sel;
    logic            s1_valid;

    logic [W-1:0]    result_q;
    logic            carry_q;
    logic            zero_q;
    op_t             s2_op;
    logic            out_valid_q;
    logic [W-1:0]    acc;

    logic            s2_free;
    logic            s2_load;
    logic            in_fire;
    logic [W-1:0]    opa;
    logic [W:0]      sum;
    logic [W-1:0]    alu_res;
    logic            alu_carry;

    logic [DIVW-1:0] div_cnt;
    logic [IDXW-1:0] digit_idx;
    logic [IDXW-1:0] idx_next;
    logic            div_wrap;

    assign s2_free       = !out_valid_q || bus.out_ready;
    assign s2_load       = s1_valid && s2_free;
    assign bus.in_ready  = !s1_valid || s2_free;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign an            = ~(DIGITS'(1) << digit_idx);

    function automatic logic [1:7] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'b0000001;
            4'h1: hex_seg = 7'b1001111;
            4'h2: hex_seg = 7'b0010010;
            4'h3: hex_seg = 7'b0000110;
            4'h4: hex_seg = 7'b1001100;
            4'h5: hex_seg = 7'b0100100;
            4'h6: hex_seg = 7'b0100000;
            4'h7: hex_seg = 7'b0001111;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0000100;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b1100000;
            4'hC: hex_seg = 7'b0110001;
            4'hD: hex_seg = 7'b1000010;
            4'hE: hex_seg = 7'b0110000;
            default: hex_seg = 7'b0111000;
        endcase
    endfunction

    // S1 captures a new transaction on handshake and empties when it moves on to S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= OP_A;
            s1_acc_sel <= 1'b0;
        end else if (in_fire) begin
            s1_valid   <= 1'b1;
            s1_a       <= bus.a;
            s1_b       <= bus.b;
            s1_op      <= op_t'(bus.op);
            s1_acc_sel <= bus.acc_sel;
        end else if (s2_load) begin
            s1_valid   <= 1'b0;
        end
    end

    // ALU evaluated on the S1 contents, with the accumulator optionally replacing A.
    always_comb begin
        opa       = s1_acc_sel ? acc : s1_a;
        sum       = {1'b0, opa} + {1'b0, s1_b};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (s1_op)
            OP_A:   alu_res = opa;
            OP_OR:  alu_res = opa | s1_b;
            OP_XOR: alu_res = opa ^ s1_b;
            OP_AND: alu_res = opa & s1_b;
            OP_SUB: begin
                alu_res   = opa - s1_b;
                alu_carry = (opa < s1_b);
            end
            OP_ADD: begin
                alu_res   = sum[W-1:0];
                alu_carry = sum[W];
            end
            OP_B:   alu_res = s1_b;
            OP_CLR: alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    // S2 loads the ALU result and flags, updates the accumulator, and holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b1;
            s2_op       <= OP_A;
            acc         <= '0;
        end else if (s2_load) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            carry_q     <= alu_carry;
            zero_q      <= (alu_res == '0);
            s2_op       <= s1_op;
            acc         <= alu_res;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Debug readout of the S1 operands, the result, or the packed S2 status.
    always_comb begin
        case (dsel)
            2'b00:   dout = s1_a;
            2'b01:   dout = s1_b;
            2'b10:   dout = result_q;
            default: dout = {{(W-5){1'b0}}, s2_op, carry_q, zero_q};
        endcase
    end

    // Next digit index: advances once per divider wrap and cycles through all digits.
    always_comb begin
        div_wrap = (div_cnt == DIVW'(SCAN_DIV - 1));
        idx_next = digit_idx;
        if (div_wrap) begin
            idx_next = (digit_idx == IDXW'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        end
    end

    // Free-running scan divider and digit index, with segments registered for the digit being lit.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            digit_idx <= '0;
            seg       <= 7'b0000001;
        end else begin
            div_cnt   <= div_wrap ? '0 : div_cnt + 1'b1;
            digit_idx <= idx_next;
            seg       <= hex_seg(result_q[4 * int'(idx_next) +: 4]);
        end
    end
endmodule

// File: tb/tb_dpu_pipe.sv
// Randomised and directed bench for dpu_pipe. A transaction-level model
// (queue of accepted operations, computed in arrival order) predicts every
// output each cycle; directed sequences pin the model with literal values.
module tb_dpu_pipe;
    localparam int W        = 8;
    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 2;

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic [2:0] op;
        int         acc_edge;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  dsel = 2'b00;
    logic [7:0]  dout;
    logic [1:7]  seg;
    logic [1:0]  an;

    dpu_pipe_if #(.W(W)) bus();

    dpu_pipe #(.W(W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .dsel (dsel),
        .dout (dout),
        .seg  (seg),
        .an   (an)
    );

    int checks = 0;
    int passes = 0;
    int edges  = 0;
    int since  = 0;
    bit started = 1'b0;

    item_t      q[$];
    item_t      newItem;
    logic [7:0] macc = 8'h00;
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;
    logic [7:0] last_r = 8'h00;
    logic       last_c = 1'b0;
    logic       last_z = 1'b1;
    logic [2:0] last_op = 3'b000;
    logic [7:0] prev_res;

    bit         s2occ;
    int         s1occ;
    bit         exp_ready;
    logic [7:0] vres;
    logic       vc;
    logic       vz;
    logic [2:0] vop;
    logic [7:0] dexp;
    int         idx;
    logic [1:0] an_exp;

    logic [6:0] hexpat [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    initial forever #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                                 input logic [2:0] iop, input logic isel);
        bus.in_valid = iv;
        bus.a        = ia;
        bus.b        = ib;
        bus.op       = iop;
        bus.acc_sel  = isel;
    endtask

    // Result of one operation from the opcode rules, in plain integer arithmetic.
    function automatic item_t computeItem(input logic [7:0] ia, input logic [7:0] ib,
                                          input logic [2:0] iop, input logic isel);
        item_t it;
        int av;
        int bv;
        int rv;
        av = isel ? int'(macc) : int'(ia);
        bv = int'(ib);
        it.c = 1'b0;
        case (iop)
            3'd0: rv = av;
            3'd1: rv = av | bv;
            3'd2: rv = av ^ bv;
            3'd3: rv = av & bv;
            3'd4: begin
                rv   = (av - bv + 256) % 256;
                it.c = (av < bv);
            end
            3'd5: begin
                rv   = (av + bv) % 256;
                it.c = ((av + bv) > 255);
            end
            3'd6: rv = bv;
            default: rv = 0;
        endcase
        it.r        = 8'(rv);
        it.z        = (rv == 0);
        it.op       = iop;
        it.acc_edge = edges + 1;
        macc        = 8'(rv);
        return it;
    endfunction

    // Per-cycle comparison of every DUT output against the transaction model.
    always @(negedge clk) begin
        s2occ     = (q.size() > 0) && (q[0].acc_edge < edges);
        s1occ     = q.size() - (s2occ ? 1 : 0);
        exp_ready = (s1occ == 0) || !s2occ || bus.out_ready;
        if (s2occ) begin
            vres = q[0].r;  vc = q[0].c;  vz = q[0].z;  vop = q[0].op;
        end else begin
            vres = last_r;  vc = last_c;  vz = last_z;  vop = last_op;
        end
        idx    = (since / SCAN_DIV) % DIGITS;
        an_exp = ~(2'b01 << idx);
        if (started) begin
            checkOutput("out_valid", 32'(bus.out_valid), 32'(s2occ));
            checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            checkOutput("result", 32'(bus.result), 32'(vres));
            checkOutput("carry", 32'(bus.carry), 32'(vc));
            checkOutput("zero", 32'(bus.zero), 32'(vz));
            case (dsel)
                2'b00:   dexp = last_a;
                2'b01:   dexp = last_b;
                2'b10:   dexp = vres;
                default: dexp = {3'b000, vop, vc, vz};
            endcase
            checkOutput("dout", 32'(dout), 32'(dexp));
            checkOutput("an", 32'(an), 32'(an_exp));
            if (bus.result === prev_res)
                checkOutput("seg", 32'(seg), 32'(hexpat[(int'(bus.result) >> (4 * idx)) & 15]));
        end
        prev_res = bus.result;
        if (rst) begin
            started = 1'b1;
            q.delete();
            macc = 8'h00;  last_a = 8'h00;  last_b = 8'h00;
            last_r = 8'h00;  last_c = 1'b0;  last_z = 1'b1;  last_op = 3'b000;
            since = 0;
        end else if (started) begin
            if (s2occ && bus.out_ready) begin
                last_r = q[0].r;  last_c = q[0].c;  last_z = q[0].z;  last_op = q[0].op;
                void'(q.pop_front());
            end
            if (bus.in_valid && exp_ready) begin
                newItem = computeItem(bus.a, bus.b, bus.op, bus.acc_sel);
                q.push_back(newItem);
                last_a = bus.a;
                last_b = bus.b;
            end
            since++;
        end
    end

    task automatic sendOne(input logic [7:0] ia, input logic [7:0] ib,
                           input logic [2:0] iop, input logic isel);
        bit done = 1'b0;
        @(posedge clk); #1;
        applyStimulus(1'b1, ia, ib, iop, isel);
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!done) checkOutput("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitValid(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        if (!seen) checkOutput(name, 32'd0, 32'd1);
    endtask

    logic [7:0] chainExp [5] = '{8'h00, 8'h03, 8'h06, 8'h09, 8'h42};
    logic [1:0] anSeq [6]    = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
    int         accepts;
    logic [1:0] prevAn;
    bit         synced;

    initial begin
        applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_result", 32'(bus.result), 32'h0);
        checkOutput("rst_carry", 32'(bus.carry), 32'd0);
        checkOutput("rst_zero", 32'(bus.zero), 32'd1);
        checkOutput("rst_an", 32'(an), 32'b10);
        checkOutput("rst_seg", 32'(seg), 32'b0000001);
        for (int d = 0; d < 3; d++) begin
            dsel = 2'(d);
            #1 checkOutput("rst_dout", 32'(dout), 32'h0);
        end
        dsel = 2'b10;

        // Add / subtract with carry and zero flags
        sendOne(8'hF0, 8'h20, 3'b101, 1'b0);
        waitValid("add_wait");
        checkOutput("add_result", 32'(bus.result), 32'h10);
        checkOutput("add_carry", 32'(bus.carry), 32'd1);
        checkOutput("add_zero", 32'(bus.zero), 32'd0);
        sendOne(8'h05, 8'h07, 3'b100, 1'b0);
        waitValid("sub_wait");
        checkOutput("sub_result", 32'(bus.result), 32'hFE);
        checkOutput("sub_borrow", 32'(bus.carry), 32'd1);
        sendOne(8'h07, 8'h07, 3'b100, 1'b0);
        waitValid("subz_wait");
        checkOutput("subz_result", 32'(bus.result), 32'h00);
        checkOutput("subz_carry", 32'(bus.carry), 32'd0);
        checkOutput("subz_zero", 32'(bus.zero), 32'd1);

        // Back-to-back accumulate chain
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            case (i)
                0: applyStimulus(1'b1, 8'h55, 8'h00, 3'b111, 1'b0);
                1, 2, 3: applyStimulus(1'b1, 8'hAA, 8'h03, 3'b101, 1'b1);
                4: applyStimulus(1'b1, 8'h00, 8'h42, 3'b110, 1'b0);
                default: bus.in_valid = 1'b0;
            endcase
            @(negedge clk);
            if (i < 5) checkOutput("chain_in_ready", 32'(bus.in_ready), 32'd1);
            if (i >= 2) begin
                checkOutput("chain_valid", 32'(bus.out_valid), 32'd1);
                checkOutput("chain_result", 32'(bus.result), 32'(chainExp[i-2]));
            end
        end

        // Backpressure: one extra accept, then stall, then in-order drain
        @(posedge clk); #1 bus.out_ready = 1'b0;
        sendOne(8'h11, 8'h22, 3'b101, 1'b0);
        waitValid("bp_first");
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'h40, 8'h01, 3'b101, 1'b0);
        accepts = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) accepts++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_accepts", 32'(accepts), 32'd1);
        checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("bp_held", 32'(bus.result), 32'h33);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_first", 32'(bus.result), 32'h33);
        @(negedge clk);
        checkOutput("bp_second_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("bp_second", 32'(bus.result), 32'h41);
        @(negedge clk);
        checkOutput("bp_drained", 32'(bus.out_valid), 32'd0);

        // Debug readout with S1 and S2 both occupied
        @(posedge clk); #1 bus.out_ready = 1'b0;
        sendOne(8'hFF, 8'h02, 3'b101, 1'b0);
        sendOne(8'h3C, 8'hA5, 3'b000, 1'b0);
        @(negedge clk);
        dsel = 2'b00; #1 checkOutput("dbg_a", 32'(dout), 32'h3C);
        dsel = 2'b01; #1 checkOutput("dbg_b", 32'(dout), 32'hA5);
        dsel = 2'b10; #1 checkOutput("dbg_result", 32'(dout), 32'h01);
        dsel = 2'b11; #1 checkOutput("dbg_status", 32'(dout), 32'h16);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Display scan of result 0x9B
        sendOne(8'h00, 8'h9B, 3'b110, 1'b0);
        waitValid("disp_wait");
        repeat (3) @(negedge clk);
        synced = 1'b0;
        prevAn = an;
        for (int k = 0; k < 20 && !synced; k++) begin
            @(negedge clk);
            if (prevAn == 2'b01 && an == 2'b10) synced = 1'b1;
            prevAn = an;
        end
        if (!synced) checkOutput("disp_sync", 32'd0, 32'd1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput("disp_an", 32'(an), 32'(anSeq[k]));
            checkOutput("disp_seg", 32'(seg), (anSeq[k] == 2'b10) ? 32'b1100000 : 32'b0000100);
        end

        // Random traffic with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (i == 200) begin
                rst = 1'b1;
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
                checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
                checkOutput("mid_rst_result", 32'(bus.result), 32'h0);
                checkOutput("mid_rst_zero", 32'(bus.zero), 32'd1);
                @(negedge clk);
                checkOutput("mid_rst_no_pulse", 32'(bus.out_valid), 32'd0);
                @(posedge clk); #1;
            end
            applyStimulus(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
                          3'($urandom), 1'($urandom));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            dsel = 2'($urandom);
        end

        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("drain_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
